// File: rtl/l15_tag_pkg.sv
// Shared types and constants for the L1.5 tag sweep controller.
package l15_tag_pkg;

  localparam int unsigned L15_NB_WAYS    = 4;
  localparam int unsigned L15_TAG_WIDTH  = 7;
  localparam int unsigned L15_ADDR_WIDTH = 6;
  localparam int unsigned NB_SETS        = 2 ** L15_ADDR_WIDTH;
  localparam int unsigned VALID_BIT      = L15_TAG_WIDTH - 1;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    FLUSH
  } tag_sweep_state_e;

endpackage

// File: rtl/l15_sweep_counter.sv
// Set-index counter for invalidation sweeps; wraps naturally and flags the last set.
module l15_sweep_counter #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ADDR_WIDTH'(1);
    end
  end

  assign tc = (cnt == {ADDR_WIDTH{1'b1}});

endmodule

// File: rtl/l15_tag_sweep_ctrl.sv
// Arbitrates controller tag accesses against init/flush invalidation sweeps
// in front of the per-way single-port tag RAMs.
module l15_tag_sweep_ctrl
  import l15_tag_pkg::*;
#(
  parameter int unsigned NB_WAYS    = L15_NB_WAYS,
  parameter int unsigned TAG_WIDTH  = L15_TAG_WIDTH,
  parameter int unsigned ADDR_WIDTH = L15_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req_i,
  output logic                  flush_ack_o,
  output logic                  busy_o,
  input  logic                  ctrl_req_i,
  output logic                  ctrl_gnt_o,
  input  logic                  ctrl_write_i,
  input  logic [NB_WAYS-1:0]    ctrl_way_i,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr_i,
  input  logic [TAG_WIDTH-1:0]  ctrl_wdata_i,
  output logic [NB_WAYS-1:0]    tag_req_o,
  output logic                  tag_write_o,
  output logic [ADDR_WIDTH-1:0] tag_addr_o,
  output logic [TAG_WIDTH-1:0]  tag_wdata_o
);

  tag_sweep_state_e state_q, state_d;
  logic pending_q, pending_d;
  logic ack_q, ack_d;
  logic [ADDR_WIDTH-1:0] cnt;
  logic cnt_tc;
  logic cnt_clr, cnt_en;

  assign cnt_en  = (state_q != IDLE);
  assign cnt_clr = (state_q == IDLE);

  l15_sweep_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  // Next state, pending merge and the RAM access mux.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ack_d       = 1'b0;
    busy_o      = 1'b1;
    ctrl_gnt_o  = 1'b0;
    tag_req_o   = '0;
    tag_write_o = 1'b0;
    tag_addr_o  = '0;
    tag_wdata_o = '0;
    flush_ack_o = ack_q;

    unique case (state_q)
      INIT, FLUSH: begin
        tag_req_o   = '1;
        tag_write_o = 1'b1;
        tag_addr_o  = cnt;
        if (flush_req_i) begin
          pending_d = 1'b1;
        end
        if (cnt_tc) begin
          // A request seen during the sweep chains straight into another one.
          if (pending_q || flush_req_i) begin
            state_d   = FLUSH;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
            ack_d   = (state_q == FLUSH);
          end
        end
      end
      IDLE: begin
        busy_o = 1'b0;
        if (flush_req_i) begin
          state_d = FLUSH;
        end else if (ctrl_req_i) begin
          ctrl_gnt_o  = 1'b1;
          tag_req_o   = ctrl_write_i ? ctrl_way_i : '1;
          tag_write_o = ctrl_write_i;
          tag_addr_o  = ctrl_addr_i;
          tag_wdata_o = ctrl_wdata_i;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // Hold every output at its reset value while rst is asserted.
    if (rst) begin
      flush_ack_o = 1'b0;
      busy_o      = 1'b1;
      ctrl_gnt_o  = 1'b0;
      tag_req_o   = '0;
      tag_write_o = 1'b0;
      tag_addr_o  = '0;
      tag_wdata_o = '0;
    end
  end

`ifndef SYNTHESIS
  a_onehot_write_way : assert property (@(posedge clk) disable iff (rst)
    (ctrl_gnt_o && ctrl_write_i) |-> $onehot(ctrl_way_i))
    else $error("controller write with non-one-hot way select %b", ctrl_way_i);
`endif

endmodule

// File: doc/l15_tag_sweep_ctrl.md
Name: l15_tag_sweep_ctrl

Overview:
- Sits directly upstream of the per-way L1.5 tag memories (single-port, 1-cycle read latency).
- Arbitrates cache-controller tag accesses against internal invalidation sweeps.
- After reset and on every flush request, it walks all sets and writes all-zero tags (valid=0) to every way.
- Cache-controller lookups and refills are stalled while a sweep is running.

Parameters:
- NB_WAYS, 4, number of tag RAM instances driven (one per way)
- TAG_WIDTH, 7, tag RAM data width including valid bit at MSB
- ADDR_WIDTH, 6, set-index width; sweep covers 2**ADDR_WIDTH sets

Ports:
- clk  in  1  clock
- rst  in  1  reset. Reset is asynchronous and active-high.
- flush_req_i  in  1  level request for full invalidation
- flush_ack_o  out  1  one-cycle pulse when flush sweep completes
- busy_o  out  1  sweep in progress (INIT or FLUSH)
- ctrl_req_i  in  1  controller tag access request
- ctrl_gnt_o  out  1  access accepted this cycle
- ctrl_write_i  in  1  1=refill write, 0=lookup read
- ctrl_way_i  in  NB_WAYS  one-hot way select for writes; ignored for reads (all ways read)
- ctrl_addr_i  in  ADDR_WIDTH  set index
- ctrl_wdata_i  in  TAG_WIDTH  tag to write
- tag_req_o  out  NB_WAYS  per-way RAM request
- tag_write_o  out  1  shared RAM write enable
- tag_addr_o  out  ADDR_WIDTH  shared RAM address
- tag_wdata_o  out  TAG_WIDTH  shared RAM write data

Behaviour:
- FSM states: INIT, IDLE, FLUSH. Reset enters INIT with set counter cnt=0.
- Reset values:
  - flush_ack_o=0, busy_o=1, ctrl_gnt_o=0.
  - tag_req_o=0, tag_write_o=0, tag_addr_o=0, tag_wdata_o=0.
- RAM outputs are combinational from state and inputs (no added latency). Read data returns from the RAMs 1 cycle after the grant cycle. This block does not touch the read data.
- INIT/FLUSH cycle behaviour:
  - tag_req_o='1, tag_write_o=1, tag_addr_o=cnt, tag_wdata_o=0.
  - cnt increments each cycle.
  - ctrl_gnt_o=0 and busy_o=1.
- Sweep length: exactly 2**ADDR_WIDTH cycles. On the cycle cnt==2**ADDR_WIDTH-1, the next state is IDLE and cnt wraps to 0.
- Leaving FLUSH: flush_ack_o pulses in the first IDLE cycle. Leaving INIT produces no ack.
- IDLE, ctrl_req_i=1 and no flush pending:
  - ctrl_gnt_o=1 combinationally, tag_addr_o=ctrl_addr_i, tag_write_o=ctrl_write_i, tag_wdata_o=ctrl_wdata_i.
  - tag_req_o = ctrl_way_i when writing, '1 when reading.
  - A zero or multi-hot ctrl_way_i on a write is driven through unchanged. Flag it with a simulation assertion only.
- IDLE, ctrl_req_i=0: all RAM requests 0, tag_wdata_o held 0.
- Flush priority: in IDLE, flush_req_i=1 wins over ctrl_req_i in the same cycle. ctrl_gnt_o=0 that cycle and the next state is FLUSH. The cycle with flush_req_i seen performs no RAM access.
- pending flag:
  - Set by flush_req_i seen in INIT or FLUSH.
  - Cleared when a FLUSH sweep starts.
  - At sweep end with pending=1, the FSM goes to FLUSH (no IDLE cycle). flush_ack_o pulses only at the end of that final sweep.
  - One ack per completed FLUSH sweep. A flush request merged into a pending sweep gets no extra ack.
- flush_req_i still high in the ack cycle: treated as a new request, so a new FLUSH starts the next cycle. The requester must drop flush_req_i on the ack.
- rst asserted mid-sweep: immediate return to INIT and cnt=0. The pending flag clears and no ack is produced.
- cnt is ADDR_WIDTH bits with natural wrap. No state beyond 2**ADDR_WIDTH sets is addressable.

Decomposition:
- Package l15_tag_pkg:
  - state enum tag_sweep_state_e {INIT, IDLE, FLUSH}
  - valid-bit position constant (TAG_WIDTH-1)
  - localparam NB_SETS = 2**ADDR_WIDTH
- One sub-module is natural: l15_sweep_counter (ADDR_WIDTH counter with clear, enable, terminal-count flag). The FSM and access mux stay in the top module.

Test Plan:
- Reset release, ADDR_WIDTH=6, NB_WAYS=4 -> 64 consecutive cycles with tag_req_o=4'b1111, write=1, addr 0..63, wdata=0, busy_o=1; then IDLE, busy_o=0, no ack.
- IDLE read ctrl_addr_i=5 -> same-cycle gnt=1, tag_req_o=4'b1111, write=0, addr=5; RAM model returns stored tags next cycle.
- IDLE write ctrl_way_i=4'b0100, addr=9, wdata=7'h45 -> only way2 written; subsequent read at 9 shows 7'h45 in way2 and 0 in others.
- flush_req_i and ctrl_req_i same IDLE cycle -> gnt=0, 64-cycle sweep, flush_ack_o single pulse on cycle 65, controller then granted.
- flush_req_i pulsed at sweep cycle 30 of FLUSH -> second back-to-back 64-cycle sweep, exactly one ack after 128 sweep cycles.
- rst asserted at INIT cycle 20 for 2 cycles -> sweep restarts at addr 0, full 64 cycles, outputs at reset values while rst high.
